// File: rtl/simplerisc_pkg.sv
// Shared SimpleRisc definitions: control-flag layout and defaults used by the OF/EX boundary.
package simplerisc_pkg;

    localparam int CTRL_W    = 9;
    localparam int ALU_W_DEF = 5;

    localparam int CTRL_IS_CALL      = 8;
    localparam int CTRL_IS_UBRANCH   = 7;
    localparam int CTRL_IS_WB        = 6;
    localparam int CTRL_IS_IMMEDIATE = 5;
    localparam int CTRL_IS_RET       = 4;
    localparam int CTRL_IS_BGT       = 3;
    localparam int CTRL_IS_BEQ       = 2;
    localparam int CTRL_IS_LD        = 1;
    localparam int CTRL_IS_ST        = 0;

    localparam logic [CTRL_W-1:0] NOP_CTRL = '0;

    // An invalid slot must look like a NOP to Execute.
    function automatic logic [CTRL_W-1:0] gate_ctrl(input logic vld, input logic [CTRL_W-1:0] ctrl);
        return vld ? ctrl : NOP_CTRL;
    endfunction

endpackage

// File: rtl/of_ex_slot.sv
// One OF->EX storage entry: valid bit plus flattened payload, with load and clear.
module of_ex_slot #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    // Clear wins over load so a flush can never be overridden by a refill.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
    end

endmodule

// File: rtl/of_ex_stage_reg.sv
// Flow-controlled OF->EX pipeline register with optional skid entry, flush and saturating stall counter.
module of_ex_stage_reg
    import simplerisc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ALU_W  = ALU_W_DEF,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [DATA_W-1:0] in_op1,
    input  logic [DATA_W-1:0] in_op2,
    input  logic [DATA_W-1:0] in_immd,
    input  logic [DATA_W-1:0] in_btarget,
    input  logic [ALU_W-1:0]  in_alu,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_instr,
    output logic [DATA_W-1:0] out_op1,
    output logic [DATA_W-1:0] out_op2,
    output logic [DATA_W-1:0] out_immd,
    output logic [DATA_W-1:0] out_btarget,
    output logic [ALU_W-1:0]  out_alu,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int PAY_W = 6 * DATA_W + ALU_W + CTRL_W;

    logic [PAY_W-1:0] in_pay;
    logic [PAY_W-1:0] main_d;
    logic [PAY_W-1:0] main_q;
    logic [PAY_W-1:0] skid_q;
    logic             main_v;
    logic             skid_v;
    logic             xfer_in;
    logic             xfer_out;
    logic             main_from_skid;
    logic             main_from_in;
    logic             main_load;
    logic             main_clear;
    logic             skid_load;
    logic             skid_clear;
    logic [ALU_W-1:0] main_alu;
    logic [CTRL_W-1:0] main_ctrl;

    assign in_pay = {in_pc, in_instr, in_op1, in_op2, in_immd, in_btarget, in_alu, in_ctrl};

    assign xfer_in  = in_valid & in_ready & ~flush;
    assign xfer_out = main_v & out_ready;

    // Skid has priority into main so FIFO order is kept; new input only bypasses an empty skid.
    assign main_from_skid = skid_v & xfer_out;
    assign main_from_in   = xfer_in & ~skid_v & (~main_v | out_ready);
    assign main_load      = main_from_skid | main_from_in;
    assign main_d         = main_from_skid ? skid_q : in_pay;
    assign main_clear     = flush | (xfer_out & ~main_load);
    assign skid_load      = xfer_in & main_v & ~out_ready;
    assign skid_clear     = flush | main_from_skid;

    of_ex_slot #(.W(PAY_W)) u_main (
        .clk   (Clk),
        .rst   (Rst),
        .load  (main_load),
        .clear (main_clear),
        .d     (main_d),
        .valid (main_v),
        .q     (main_q)
    );

    generate
        if (SKID != 0) begin : g_skid
            of_ex_slot #(.W(PAY_W)) u_skid (
                .clk   (Clk),
                .rst   (Rst),
                .load  (skid_load),
                .clear (skid_clear),
                .d     (in_pay),
                .valid (skid_v),
                .q     (skid_q)
            );
            // Depends only on a register (plus reset), so OF sees no combinational path from EX.
            assign in_ready = ~Rst & ~skid_v;
        end else begin : g_noskid
            assign skid_v   = 1'b0;
            assign skid_q   = '0;
            assign in_ready = ~Rst & (~main_v | out_ready);
        end
    endgenerate

    assign {out_pc, out_instr, out_op1, out_op2, out_immd, out_btarget, main_alu, main_ctrl} = main_q;
    assign out_valid = main_v;
    assign out_alu   = main_v ? main_alu : '0;
    assign out_ctrl  = gate_ctrl(main_v, main_ctrl);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            stall_cnt <= '0;
        end else if (main_v && !out_ready && !flush && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_of_ex_stage_reg.sv
// Scoreboard bench for of_ex_stage_reg: a SKID=1/CNT_W=4 instance and a SKID=0 instance share stimulus.
module tb_of_ex_stage_reg;

    logic        clk = 1'b0;
    logic        Rst;
    logic        in_valid;
    logic [31:0] in_pc, in_instr, in_op1, in_op2, in_immd, in_btarget;
    logic [4:0]  in_alu;
    logic [8:0]  in_ctrl;
    logic        flush;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
    logic [31:0] a_pc, a_instr, a_op1, a_op2, a_immd, a_bt;
    logic [31:0] b_pc, b_instr, b_op1, b_op2, b_immd, b_bt;
    logic [4:0]  a_alu, b_alu;
    logic [8:0]  a_ctrl, b_ctrl;
    logic [3:0]  a_stall;
    logic [15:0] b_stall;

    int checks = 0;
    int errors = 0;
    logic        mon_sel = 1'b0;
    logic [159:0] sb[$];

    always #5 clk = ~clk;

    of_ex_stage_reg #(.DATA_W(32), .ALU_W(5), .SKID(1), .CNT_W(4)) dut_a (
        .Clk(clk), .Rst(Rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .in_op1(in_op1), .in_op2(in_op2),
        .in_immd(in_immd), .in_btarget(in_btarget), .in_alu(in_alu), .in_ctrl(in_ctrl),
        .flush(flush), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_pc(a_pc), .out_instr(a_instr), .out_op1(a_op1), .out_op2(a_op2),
        .out_immd(a_immd), .out_btarget(a_bt), .out_alu(a_alu), .out_ctrl(a_ctrl),
        .stall_cnt(a_stall)
    );

    of_ex_stage_reg #(.DATA_W(32), .ALU_W(5), .SKID(0), .CNT_W(16)) dut_b (
        .Clk(clk), .Rst(Rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .in_op1(in_op1), .in_op2(in_op2),
        .in_immd(in_immd), .in_btarget(in_btarget), .in_alu(in_alu), .in_ctrl(in_ctrl),
        .flush(flush), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_pc(b_pc), .out_instr(b_instr), .out_op1(b_op1), .out_op2(b_op2),
        .out_immd(b_immd), .out_btarget(b_bt), .out_alu(b_alu), .out_ctrl(b_ctrl),
        .stall_cnt(b_stall)
    );

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [31:0] pc);
        in_valid   = v;
        in_pc      = pc;
        in_instr   = ~pc;
        in_op1     = pc + 32'd1;
        in_op2     = pc + 32'd2;
        in_immd    = pc + 32'd3;
        in_btarget = pc + 32'd4;
        in_alu     = pc[6:2] + 5'd1;
        in_ctrl    = {pc[6:2], pc[5:2]} ^ 9'h155;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs settle at posedge+1, so the negedge sees exactly what the next edge will transfer.
    always @(negedge clk) begin
        logic [159:0] obs;
        logic [159:0] exp;
        if (Rst || flush) begin
            sb.delete();
        end else begin
            if (mon_sel ? (b_out_valid && out_ready) : (a_out_valid && out_ready)) begin
                obs = mon_sel ? {18'd0, b_pc, b_instr, b_op1, b_op2, b_bt, b_alu, b_ctrl}
                              : {18'd0, a_pc, a_instr, a_op1, a_op2, a_bt, a_alu, a_ctrl};
                if (sb.size() == 0) begin
                    chk("sb_unexpected_out", 160'(sb.size()), 160'd1);
                end else begin
                    exp = sb.pop_front();
                    chk("sb_payload", obs, exp);
                end
            end
            if (in_valid && (mon_sel ? b_in_ready : a_in_ready))
                sb.push_back({18'd0, in_pc, in_instr, in_op1, in_op2, in_btarget, in_alu, in_ctrl});
        end
    end

    initial begin
        Rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drv(1'b1, 32'h99);
        repeat (3) tick();
        #1;
        chk("rst_in_ready",  160'(a_in_ready), 160'd0);
        chk("rst_out_valid", 160'(a_out_valid), 160'd0);
        chk("rst_out_pc",    160'(a_pc), 160'd0);
        chk("rst_out_ctrl",  160'(a_ctrl), 160'd0);
        chk("rst_stall",     160'(a_stall), 160'd0);
        chk("rst_b_in_ready", 160'(b_in_ready), 160'd0);
        Rst = 1'b0;
        drv(1'b0, 32'h0);
        #1;
        chk("rel_in_ready",   160'(a_in_ready), 160'd1);
        chk("rel_b_in_ready", 160'(b_in_ready), 160'd1);

        // Streaming at full rate
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 32'(i * 4));
            tick();
            #1;
            chk("stream_vld", 160'(a_out_valid), 160'd1);
            chk("stream_pc",  160'(a_pc), 160'(i * 4));
        end
        drv(1'b0, 32'h0);
        tick();
        chk("stream_idle_vld", 160'(a_out_valid), 160'd0);

        // Backpressure fills main then skid
        out_ready = 1'b0;
        drv(1'b1, 32'h10);
        tick();
        drv(1'b1, 32'h14);
        tick();
        drv(1'b0, 32'h0);
        repeat (3) tick();
        #1;
        chk("bp_pc",       160'(a_pc), 160'h10);
        chk("bp_in_ready", 160'(a_in_ready), 160'd0);
        chk("bp_stall",    160'(a_stall), 160'd4);
        out_ready = 1'b1;
        tick();
        #1;
        chk("bp_rel_pc",       160'(a_pc), 160'h14);
        chk("bp_rel_in_ready", 160'(a_in_ready), 160'd1);
        tick();
        chk("bp_drained_vld", 160'(a_out_valid), 160'd0);

        // Flush with both entries occupied
        out_ready = 1'b0;
        drv(1'b1, 32'h18);
        tick();
        drv(1'b1, 32'h1C);
        tick();
        #1;
        chk("fl_pre_in_ready", 160'(a_in_ready), 160'd0);
        flush = 1'b1;
        drv(1'b1, 32'h20);
        tick();
        flush = 1'b0;
        drv(1'b0, 32'h0);
        #1;
        chk("fl_vld",      160'(a_out_valid), 160'd0);
        chk("fl_ctrl",     160'(a_ctrl), 160'd0);
        chk("fl_alu",      160'(a_alu), 160'd0);
        chk("fl_in_ready", 160'(a_in_ready), 160'd1);
        chk("fl_stall",    160'(a_stall), 160'd5);
        out_ready = 1'b1;
        repeat (3) tick();
        chk("fl_after_vld", 160'(a_out_valid), 160'd0);

        // Saturation of the 4-bit stall counter
        out_ready = 1'b0;
        drv(1'b1, 32'h24);
        tick();
        drv(1'b0, 32'h0);
        repeat (20) tick();
        #1;
        chk("sat_stall", 160'(a_stall), 160'd15);
        chk("sat_pc",    160'(a_pc), 160'h24);

        // Reset in the middle of a stall
        Rst = 1'b1;
        tick();
        #1;
        chk("mid_rst_stall",    160'(a_stall), 160'd0);
        chk("mid_rst_vld",      160'(a_out_valid), 160'd0);
        chk("mid_rst_pc",       160'(a_pc), 160'd0);
        chk("mid_rst_in_ready", 160'(a_in_ready), 160'd0);
        Rst = 1'b0;
        mon_sel = 1'b1;

        // SKID=0: combinational in_ready and back-to-back transfers
        drv(1'b1, 32'h40);
        #1;
        chk("s0_empty_in_ready", 160'(b_in_ready), 160'd1);
        tick();
        drv(1'b1, 32'h44);
        #1;
        chk("s0_blocked_in_ready", 160'(b_in_ready), 160'd0);
        out_ready = 1'b1;
        #1;
        chk("s0_open_in_ready", 160'(b_in_ready), 160'd1);
        tick();
        #1;
        chk("s0_vld", 160'(b_out_valid), 160'd1);
        chk("s0_pc1", 160'(b_pc), 160'h44);
        drv(1'b1, 32'h48);
        tick();
        #1;
        chk("s0_pc2", 160'(b_pc), 160'h48);
        drv(1'b0, 32'h0);
        tick();
        #1;
        chk("s0_idle_vld", 160'(b_out_valid), 160'd0);
        chk("sb_drained",  160'(sb.size()), 160'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/of_ex_stage_reg.md
# of_ex_stage_reg

Parametrised OF→EX pipeline register for the SimpleRisc pipeline, replacing the fixed negedge latch with a synchronous, flow-controlled stage. It carries the instruction, PC, operands, immediate, branch target, ALU signal and decoded control flags from Operand Fetch into Execute. It adds a valid/ready handshake, an optional skid entry, a flush input for branch redirects, and a saturating stall counter.

## Interface
- DATA_W, 32: width of PC, instruction, op1, op2, Immd, Branch_Target.
- ALU_W, 5: width of AluSignal.
- SKID, 1: 1 = two-entry elastic buffer with registered in_ready; 0 = single entry, combinational in_ready.
- CNT_W, 16: stall counter width.

Clock and reset: one clock; reset is synchronous and active-high.

- Clk  in  1  rising-edge clock.
- Rst  in  1  synchronous, active-high reset.
- in_valid  in  1  OF presents a decoded instruction.
- in_ready  out  1  stage accepts this cycle.
- in_pc, in_instr, in_op1, in_op2, in_immd, in_btarget  in  DATA_W each  OF payload.
- in_alu  in  ALU_W  AluSignal.
- in_ctrl  in  9  {IsCall, IsUBranch, IsWb, IsImmediate, IsRet, IsBgt, IsBeq, IsLd, IsSt}, bit 8 down to 0.
- flush  in  1  discard all held and incoming instructions this cycle.
- out_valid  out  1  EX sees a valid instruction.
- out_ready  in  1  EX consumes this cycle.
- out_pc, out_instr, out_op1, out_op2, out_immd, out_btarget  out  DATA_W  registered payload.
- out_alu  out  ALU_W;  out_ctrl  out  9.
- stall_cnt  out  CNT_W  cycles with out_valid & !out_ready, saturating.

## Operation
- Transfer in: in_valid & in_ready & !flush. Transfer out: out_valid & out_ready.
- Main entry drives the outputs. When out_valid = 0, out_ctrl and out_alu are forced to 0, so EX sees a NOP. The payload holds its last value.
- SKID=1:
  - in_ready = !skid_valid (registered).
  - Accept while main is full and out_ready = 0: the payload goes to skid.
  - Main drains with skid full: skid moves to main, and skid_valid clears.
  - Accept and drain in the same cycle with skid empty: the new payload goes straight to main.
- SKID=0: in_ready = !main_valid | out_ready, combinational.
- flush: both entries are invalidated at the clock edge and input is not captured, regardless of in_valid, out_ready, or skid state. in_ready (SKID=1) is 1 the cycle after.
- stall_cnt: increments when out_valid & !out_ready & !flush, saturates at all-ones, and never wraps.
- Ordering is strict FIFO. No instruction is dropped or duplicated except under flush.

## Timing
- Reset: all entries invalid, every output 0. in_ready is 0 during Rst and 1 in the first cycle after Rst deasserts.
- Latency: 1 cycle from in-transfer to out_valid.
- Throughput: 1 instruction per cycle while out_ready = 1.
- SKID=1: after one stalled accept, in_ready drops in the next cycle. It returns the cycle after the skid drains into main.
- Rst has priority over flush; flush has priority over transfers.
- Rst asserted mid-stall clears stall_cnt and both entries.

## Structure
- Shared package simplerisc_pkg:
  - CTRL_W = 9.
  - Bit-index localparams for the nine control flags.
  - ALU_W default.
  - NOP_CTRL = 0.
- Sub-module of_ex_slot: one storage entry holding valid bit, payload, alu and ctrl, with load and clear inputs. Instantiated twice, and once when SKID=0.

## Test plan
- Reset: hold Rst 3 cycles with in_valid=1 → all outputs 0, in_ready=0. Cycle after release: in_ready=1.
- Streaming (SKID=1, out_ready=1): feed PC 0x00, 0x04, 0x08 on consecutive cycles → out_pc 0x00, 0x04, 0x08 on the next three cycles, out_valid continuously 1.
- Backpressure: out_ready=0 for 4 cycles while feeding PC 0x10, 0x14 → main holds 0x10, skid holds 0x14, in_ready=0, stall_cnt=4. Release → 0x10 then 0x14 in order, with no loss.
- Flush: flush with both entries full and in_valid=1 carrying PC 0x20 → next cycle out_valid=0, out_ctrl=0, in_ready=1, and PC 0x20 never appears.
- Saturation (CNT_W=4): out_ready=0 for 20 cycles with a valid instruction held → stall_cnt stays at 15.
- SKID=0: out_ready=0 with main full → in_ready=0 in the same cycle. Raise out_ready → in_ready=1 combinationally, and back-to-back transfer occurs.
